// File: rtl/y_result_collector.sv
// Sign-magnitude to two's-complement result collector: one-entry stage register feeding a
// show-ahead FIFO with write counter and sticky overflow. Optional accumulator: YRC_ACC_EN.
module y_result_collector #(
    parameter int DEPTH = 8,
    parameter int ACC_W = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [12:0]              in_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [12:0]              out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              wr_count,
    output logic                     overflow,
    output logic [ACC_W-1:0]         acc_sum
);
    localparam int AW = $clog2(DEPTH);

    logic              s_valid_q, s_valid_d;
    logic [12:0]       s_data_q, s_data_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic              overflow_q, overflow_d;
    logic [12:0]       mem_q [DEPTH];

    logic              full;
    logic              pop;
    logic              wr_en;
    logic              mem_we;
    logic [12:0]       y_conv;

    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign wr_count  = wr_count_q;
    assign overflow  = overflow_q;

    always_comb begin
        // Negative zero collapses to plain zero.
        if (in_y[11:0] == 12'd0) begin
            y_conv = 13'd0;
        end else if (in_y[12]) begin
            y_conv = ~{1'b0, in_y[11:0]} + 13'd1;
        end else begin
            y_conv = {1'b0, in_y[11:0]};
        end
    end

    always_comb begin
        full  = (level_q == (AW+1)'(DEPTH));
        pop   = out_valid && out_ready;
        wr_en = s_valid_q && (!full || pop);

        s_valid_d  = in_valid;
        s_data_d   = y_conv;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        wr_count_d = wr_count_q;
        overflow_d = overflow_q | (s_valid_q && full && !pop);
        mem_we     = wr_en;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_count_q != 16'hFFFF) begin
                wr_count_d = wr_count_q + 16'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (!wr_en && pop) begin
            level_d = level_q - (AW+1)'(1);
        end

        if (clr) begin
            s_valid_d  = 1'b0;
            s_data_d   = 13'd0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            wr_count_d = 16'd0;
            overflow_d = 1'b0;
            mem_we     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid_q  <= 1'b0;
            s_data_q   <= 13'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            wr_count_q <= 16'd0;
            overflow_q <= 1'b0;
        end else begin
            s_valid_q  <= s_valid_d;
            s_data_q   <= s_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            wr_count_q <= wr_count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; stale words are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[wr_ptr_q] <= s_data_q;
        end
    end

`ifdef YRC_ACC_EN
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum_ext;

    always_comb begin
        sum_ext = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-12){s_data_q[12]}}, s_data_q};
        acc_d   = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (wr_en) begin
            // Top two bits disagree: the signed sum left the ACC_W range.
            if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
                acc_d = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                acc_d = sum_ext[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_sum = acc_q;
`else
    assign acc_sum = '0;
`endif

endmodule

// File: tb/tb_y_result_collector.sv
// Scoreboard bench for y_result_collector: stimulus pushes expected words, a monitor checks pops.
module tb_y_result_collector;
    localparam int DEPTH = 8;
    localparam int ACC_W = 24;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    clr = 1'b0;
    logic                    in_valid = 1'b0;
    logic [12:0]             in_y = 13'd0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [12:0]             out_data;
    logic [$clog2(DEPTH):0]  level;
    logic [15:0]             wr_count;
    logic                    overflow;
    logic [ACC_W-1:0]        acc_sum;

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];

    y_result_collector #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .wr_count(wr_count), .overflow(overflow), .acc_sum(acc_sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && !clr && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected nothing", out_data);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got 0x%0h expected 0x%0h", out_data, e);
                end else begin
                    $display("ok   pop_data: 0x%0h", out_data);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [12:0] y, input logic [12:0] e, input bit keep);
        in_valid = 1'b1;
        in_y     = y;
        if (keep) exp_q.push_back(e);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        out_ready = 1'b0;
        chk("drain_empty_queue", exp_q.size(), 0);
        tick(1);
        chk("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_acc_sum", acc_sum, 0);

        // Two-edge latency, negative input
        send(13'h1005, 13'h1FFB, 1);
        chk("lat_edge1_out_valid", out_valid, 0);
        tick(1);
        chk("lat_edge2_out_valid", out_valid, 1);
        chk("lat_out_data", out_data, 13'h1FFB);
        chk("lat_level", level, 1);
        chk("lat_wr_count", wr_count, 1);
        drain();

        // Negative zero and max positive
        send(13'h1000, 13'h0000, 1);
        send(13'h0FFF, 13'h0FFF, 1);
        tick(2);
        chk("conv_level", level, 2);
        drain();

        // Overflow: 10 inputs into an 8-deep FIFO with no pops
        pulse_clr();
        for (int i = 1; i <= 10; i++) begin
            send(13'(i), 13'(i), i <= 8);
        end
        tick(2);
        chk("ovf_level", level, 8);
        chk("ovf_wr_count", wr_count, 8);
        chk("ovf_flag", overflow, 1);
        drain();
        chk("ovf_sticky", overflow, 1);

        // clr at level 3 together with in_valid and out_ready
        send(13'h0011, 13'h0011, 1);
        send(13'h1022, 13'h1FDE, 1);
        send(13'h0033, 13'h0033, 1);
        tick(2);
        chk("clr_pre_level", level, 3);
        clr = 1'b1; in_valid = 1'b1; in_y = 13'h0123; out_ready = 1'b1;
        tick(1);
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        chk("clr_level", level, 0);
        chk("clr_out_valid", out_valid, 0);
        chk("clr_wr_count", wr_count, 0);
        chk("clr_overflow", overflow, 0);
        tick(3);
        chk("clr_sample_dropped", out_valid, 0);

        // Full FIFO with continuous pop and push: no drops
        pulse_clr();
        for (int i = 1; i <= 9; i++) begin
            send(13'(i), 13'(i), 1);
        end
        out_ready = 1'b1;
        for (int i = 10; i <= 20; i++) begin
            send(13'(i), 13'(i), 1);
            chk("full_stream_level", level, 8);
        end
        chk("full_stream_overflow", overflow, 0);
        tick(1);
        drain();
        chk("full_stream_wr_count", wr_count, 20);

        // Accumulator
        pulse_clr();
        send(13'h0FFF, 13'h0FFF, 1);
        send(13'h1FFF, 13'h1001, 1);
        send(13'h0064, 13'h0064, 1);
        tick(2);
`ifdef YRC_ACC_EN
        chk("acc_sum", acc_sum, 100);
`else
        chk("acc_sum", acc_sum, 0);
`endif
        drain();

        // Reset mid-stream discards stored and in-flight entries
        send(13'h0005, 13'h0005, 1);
        send(13'h0006, 13'h0006, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_level", level, 0);
        chk("midrst_out_valid", out_valid, 0);
        tick(3);
        chk("midrst_inflight_gone", out_valid, 0);
        chk("midrst_wr_count", wr_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
